// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receive types, constants and helpers
package uart_rx_pkg;

    localparam int UART_MIN_DATA_BITS  = 5;
    localparam int UART_DEF_OVERSAMPLE = 16;
    localparam int UART_DEF_DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } uart_rx_state_e;

    typedef struct packed {
        logic                           brk;
        logic                           frm_err;
        logic                           par_err;
        logic [UART_DEF_DATA_W_MAX-1:0] data;
    } uart_rx_word_t;

    // Clamp a requested character length into the supported range.
    function automatic logic [3:0] uart_clamp_bits(input logic [3:0] bits, input int max_bits);
        if (int'(bits) < UART_MIN_DATA_BITS) return 4'(UART_MIN_DATA_BITS);
        if (int'(bits) > max_bits) return 4'(max_bits);
        return bits;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through FIFO
module uart_rx_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    // Head is forced to zero when empty so the outputs are defined out of reset.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - oversampling UART receiver with status FIFO
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int DATA_W_MAX  = UART_DEF_DATA_W_MAX,
    parameter int OVERSAMPLE  = UART_DEF_OVERSAMPLE,
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [3:0]                    cfg_bits,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          cfg_stop2,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [DATA_W_MAX-1:0]         rx_data,
    output logic                          rx_par_err,
    output logic                          rx_frm_err,
    output logic                          rx_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int WORD_W = DATA_W_MAX + 3;
    localparam logic [SCNT_W-1:0] S_LO   = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] S_MID  = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] S_HI   = SCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SCNT_W-1:0] S_LAST = SCNT_W'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    uart_rx_state_e         state_q, state_d;
    logic [DIV_W-1:0]       pre_q, pre_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [3:0]             bits_q, bits_d;
    logic [3:0]             bit_q, bit_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   stop2_q, stop2_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   frm_q, frm_d;
    logic [DATA_W_MAX-1:0]  data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic                   rx_s;
    logic                   tick;
    logic                   vote;
    logic                   vote_now;
    logic                   push;
    logic                   push_brk;
    logic                   push_frm;
    logic                   par_err_w;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [WORD_W-1:0]      push_word;
    logic [WORD_W-1:0]      head_word;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign par_err_w = par_en_q && ((^{data_q, par_bit_q}) != par_odd_q);
    assign push_word = {push_brk, push_frm, par_err_w, data_q};
    assign pop       = rx_valid && rx_ready;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        rx_prev_d  = rx_s;
        state_d    = state_q;
        pre_d      = pre_q;
        div_d      = div_q;
        scnt_d     = scnt_q;
        samp_d     = samp_q;
        bits_d     = bits_q;
        bit_d      = bit_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        par_bit_d  = par_bit_q;
        stop_idx_d = stop_idx_q;
        frm_d      = frm_q;
        data_d     = data_q;
        tick       = 1'b0;
        push       = 1'b0;
        push_brk   = 1'b0;
        push_frm   = 1'b0;

        // Prescaler and sample counter are held at zero while idle so each frame
        // starts its bit timing from the detected start edge.
        if (state_q == IDLE) begin
            pre_d = '0;
        end else if (pre_q == div_q - DIV_W'(1)) begin
            pre_d = '0;
            tick  = 1'b1;
        end else begin
            pre_d = pre_q + DIV_W'(1);
        end

        if (state_q == IDLE) begin
            scnt_d = '0;
        end else if (tick) begin
            scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + SCNT_W'(1);
        end
        if (tick && scnt_q == S_LO) samp_d[0] = rx_s;
        if (tick && scnt_q == S_MID) samp_d[1] = rx_s;
        vote_now = tick && (scnt_q == S_HI);

        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d    = START;
                    div_d      = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                    bits_d     = uart_clamp_bits(cfg_bits, DATA_W_MAX);
                    par_en_d   = cfg_par_en;
                    par_odd_d  = cfg_par_odd;
                    stop2_d    = cfg_stop2;
                    bit_d      = '0;
                    par_bit_d  = 1'b0;
                    stop_idx_d = 1'b0;
                    frm_d      = 1'b0;
                    data_d     = '0;
                end
            end
            START: begin
                if (vote_now) begin
                    state_d = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (vote_now) begin
                    for (int i = 0; i < DATA_W_MAX; i++) begin
                        if (i == int'(bit_q)) data_d[i] = vote;
                    end
                    if (bit_q == bits_q - 4'd1) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (vote_now) begin
                    par_bit_d = vote;
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Words are pushed at the mid-sample of the final stop bit, not its end,
                // so a following start edge is never missed.
                if (vote_now) begin
                    if (!stop_idx_q) begin
                        if (data_q == '0 && !(par_en_q && par_bit_q) && !vote) begin
                            push     = 1'b1;
                            push_brk = 1'b1;
                            push_frm = 1'b1;
                            state_d  = BRK_WAIT;
                        end else if (stop2_q) begin
                            frm_d      = !vote;
                            stop_idx_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_frm = !vote;
                            state_d  = IDLE;
                        end
                    end else begin
                        push     = 1'b1;
                        push_frm = frm_q | !vote;
                        state_d  = IDLE;
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        overrun_d = (overrun_q && !overrun_clr) || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            pre_q      <= '0;
            div_q      <= DIV_W'(1);
            scnt_q     <= '0;
            samp_q     <= '0;
            bits_q     <= 4'(UART_MIN_DATA_BITS);
            bit_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            frm_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            state_q    <= state_d;
            pre_q      <= pre_d;
            div_q      <= div_d;
            scnt_q     <= scnt_d;
            samp_q     <= samp_d;
            bits_q     <= bits_d;
            bit_q      <= bit_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            par_bit_q  <= par_bit_d;
            stop_idx_q <= stop_idx_d;
            frm_q      <= frm_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign rx_valid = !fifo_empty;
    assign {rx_break, rx_frm_err, rx_par_err, rx_data} = head_word;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - scoreboard bench for uart_rx_engine
module tb_uart_rx_engine;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] cfg_div = 16'd4;
    logic [3:0]  cfg_bits = 4'd8;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic        rx_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        rx_valid;
    logic [8:0]  rx_data;
    logic        rx_par_err;
    logic        rx_frm_err;
    logic        rx_break;
    logic [3:0]  fifo_level;
    logic        overrun;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];

    uart_rx_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .cfg_div     (cfg_div),
        .cfg_bits    (cfg_bits),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_par_err  (rx_par_err),
        .rx_frm_err  (rx_frm_err),
        .rx_break    (rx_break),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted head word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none",
                         {rx_break, rx_frm_err, rx_par_err, rx_data});
            end else begin
                check("rx_word", {20'd0, rx_break, rx_frm_err, rx_par_err, rx_data},
                      {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input bit has_par,
                              input bit par_v, input int nstop, input logic [1:0] stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_v);
        for (int i = 0; i < nstop; i++) drive_bit(stop_v[i]);
        drive_bit(1'b1);
    endtask

    task automatic push_timing_check();
        int   n = 0;
        logic v_prev = 1'b0;
        while (!busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        while (busy && n < 2000) begin
            v_prev = rx_valid;
            @(negedge clk);
            n++;
        end
        check("push_timeout", n >= 2000, 0);
        check("valid_before_push", v_prev, 0);
        check("valid_after_push", rx_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx_ready = 1'b1;

        // 8N1 0xA5 with push-to-valid timing
        exp_q.push_back({3'b000, 9'h0A5});
        fork
            send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
            push_timing_check();
        join

        // 7E1 / 7O1 parity
        cfg_bits = 4'd7;
        cfg_par_en = 1'b1;
        cfg_par_odd = 1'b0;
        exp_q.push_back({3'b001, 9'h041});
        send_frame(9'h041, 7, 1'b1, 1'b1, 1, 2'b11);
        exp_q.push_back({3'b000, 9'h041});
        send_frame(9'h041, 7, 1'b1, 1'b0, 1, 2'b11);
        cfg_par_odd = 1'b1;
        exp_q.push_back({3'b000, 9'h041});
        send_frame(9'h041, 7, 1'b1, 1'b1, 1, 2'b11);

        // 9-bit, two stop bits, second stop low
        cfg_bits = 4'd9;
        cfg_par_en = 1'b0;
        cfg_stop2 = 1'b1;
        exp_q.push_back({3'b010, 9'h1FF});
        send_frame(9'h1FF, 9, 1'b0, 1'b0, 2, 2'b01);
        cfg_stop2 = 1'b0;
        exp_q.push_back({3'b000, 9'h1FF});
        send_frame(9'h1FF, 9, 1'b0, 1'b0, 1, 2'b11);

        // glitched start: low for 3 sample ticks only
        cfg_bits = 4'd8;
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("glitch_busy", busy, 0);
        exp_q.push_back({3'b000, 9'h055});
        send_frame(9'h055, 8, 1'b0, 1'b0, 1, 2'b11);

        // break: line low for 20 bit times
        exp_q.push_back({3'b110, 9'h000});
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(posedge clk);
        #1;
        check("brk_wait_busy", busy, 1);
        check("brk_level", fifo_level, 0);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("brk_idle", busy, 0);

        // overrun: 9 frames into an 8-deep FIFO with no consumer
        rx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({3'b000, 9'(8'h30 + i)});
            send_frame(9'(8'h30 + i), 8, 1'b0, 1'b0, 1, 2'b11);
        end
        check("ovr_level", fifo_level, 8);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", rx_valid, 1);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        rx_ready = 1'b1;
        for (int n = 0; n < 40 && fifo_level != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_level", fifo_level, 0);

        // reset mid-frame
        rx_ready = 1'b0;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1, 2'b11);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1, 2'b11);
        check("pre_rst_level", fifo_level, 2);
        rx = 1'b0;
        repeat (3 * BIT_CLK) @(posedge clk);
        #1;
        check("mid_frame_busy", busy, 1);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_level", fifo_level, 0);
        check("rst2_valid", rx_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_overrun", overrun, 0);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        repeat (4 * BIT_CLK) @(posedge clk);
        #1;
        check("post_rst_valid", rx_valid, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
